tiny_project_mux: RTL

//  Parametrised multi-slot user-project wrapper: hosts N_SLOTS user modules behind one

---
 rtl/tpm_pkg.sv | 40 ++++
 rtl/tiny_project_mux_if.sv | 33 +++
 rtl/tpm_cfg_shift.sv | 58 +++++
 rtl/tiny_project_mux.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/tpm_pkg.sv
// ============================================================================
// Module : tpm_pkg
// Brief  : Shared constants and config-word layout helpers for tiny_project_mux.
//          The loop bit exists only when TPM_LOOPBACK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tpm_pkg;

`ifdef TPM_LOOPBACK_EN
  localparam int LOOP_BITS = 1;
`else
  localparam int LOOP_BITS = 0;
`endif

  localparam int RST_CYC     = 4;
  localparam int RST_CNT_W   = $clog2(RST_CYC + 1);
  localparam int SYNC_STAGES = 2;

  localparam int CFG_PIN_SCLK  = 0;
  localparam int CFG_PIN_SDATA = 1;
  localparam int CFG_PIN_LATCH = 2;

  // Config word, MSB..LSB: [loop] sel, div, oe_mask
  function automatic int tpm_cfg_w(input int sel_w, input int div_w, input int out_w);
    return sel_w + div_w + out_w + LOOP_BITS;
  endfunction

  function automatic int tpm_div_lsb(input int out_w);
    return out_w;
  endfunction

  function automatic int tpm_sel_lsb(input int div_w, input int out_w);
    return out_w + div_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tiny_project_mux_if.sv
// ============================================================================
// Module : tiny_project_mux_if
// Brief  : Pad window and slot-side bundle of the multi-slot project wrapper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface tiny_project_mux_if #(
  parameter int PADS    = 38,
  parameter int N_SLOTS = 4,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 8
);
  logic [PADS-1:0]          io_in;
  logic [PADS-1:0]          io_out;
  logic [PADS-1:0]          io_oeb;
  logic [N_SLOTS*IN_W-1:0]  slot_in;
  logic [N_SLOTS*OUT_W-1:0] slot_out;
  logic [N_SLOTS-1:0]       slot_clk;
  logic [N_SLOTS-1:0]       slot_rst;

  modport master (
    input  io_in, slot_out,
    output io_out, io_oeb, slot_in, slot_clk, slot_rst
  );

  modport slave (
    output io_in, slot_out,
    input  io_out, io_oeb, slot_in, slot_clk, slot_rst
  );
endinterface

`default_nettype wire

// File: rtl/tpm_cfg_shift.sv
// ============================================================================
// Module : tpm_cfg_shift
// Brief  : Serial config port: pad synchroniser, rise detect, shadow and active
//          config registers, one-cycle update pulse on each latch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tpm_cfg_shift
  import tpm_pkg::*;
#(
  parameter int               CFG_W   = 18,
  parameter logic [CFG_W-1:0] CFG_RST = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       cfg_pins_i,
  output logic [CFG_W-1:0] cfg_o,
  output logic             cfg_update_o
);

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  prev_q;
  logic [CFG_W-1:0]            shadow_q;
  logic [CFG_W-1:0]            cfg_q;
  logic                        update_q;
  logic [2:0]                  w_pins;
  logic [2:0]                  w_rise;

  assign w_pins = sync_q[SYNC_STAGES-1];
  assign w_rise = w_pins & ~prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      prev_q   <= '0;
      shadow_q <= '0;
      cfg_q    <= CFG_RST;
      update_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], cfg_pins_i};
      prev_q   <= w_pins;
      update_q <= w_rise[CFG_PIN_LATCH];
      // A latch edge takes priority; a coincident shift edge is dropped.
      if (w_rise[CFG_PIN_LATCH]) begin
        cfg_q <= shadow_q;
      end else if (w_rise[CFG_PIN_SCLK]) begin
        shadow_q <= {shadow_q[CFG_W-2:0], w_pins[CFG_PIN_SDATA]};
      end
    end
  end

  assign cfg_o        = cfg_q;
  assign cfg_update_o = update_q;

endmodule

`default_nettype wire

// File: rtl/tiny_project_mux.sv
// ============================================================================
// Module : tiny_project_mux
// Brief  : Multi-slot user-project wrapper: slot select, per-slot clock divider
//          and reset, masked registered output window. Optional pad loopback
//          is enabled with the TPM_LOOPBACK_EN macro.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tiny_project_mux
  import tpm_pkg::*;
#(
  parameter int PADS    = 38,
  parameter int N_SLOTS = 4,
  parameter int IN_W    = 8,
  parameter int IN_LSB  = 12,
  parameter int OUT_W   = 8,
  parameter int OUT_LSB = 20,
  parameter int CFG_LSB = 8,
  parameter int DIV_W   = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  tiny_project_mux_if.master bus
);

  localparam int               SEL_W   = $clog2(N_SLOTS);
  localparam int               CFG_W   = tpm_cfg_w(SEL_W, DIV_W, OUT_W);
  localparam logic [CFG_W-1:0] CFG_RST = CFG_W'({OUT_W{1'b1}});

  logic [CFG_W-1:0]     w_cfg;
  logic                 w_cfg_update;
  logic [OUT_W-1:0]     w_oe_mask;
  logic [DIV_W-1:0]     w_div;
  logic [SEL_W-1:0]     w_sel;
  logic                 w_loop;
  logic [N_SLOTS-1:0]   w_hit;
  logic                 w_slot_ok;
  logic                 w_sel_chg;
  logic                 w_div_chg;
  logic [OUT_W-1:0]     w_slot_data;

  logic [SEL_W-1:0]     sel_prev_q;
  logic [DIV_W-1:0]     div_prev_q;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [N_SLOTS-1:0]   slot_clk_q, slot_clk_d;
  logic [N_SLOTS-1:0]   slot_rst_q, slot_rst_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic [OUT_W-1:0]     oeb_q, oeb_d;

  tpm_cfg_shift #(
    .CFG_W   (CFG_W),
    .CFG_RST (CFG_RST)
  ) u_cfg (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .cfg_pins_i   (bus.io_in[CFG_LSB +: 3]),
    .cfg_o        (w_cfg),
    .cfg_update_o (w_cfg_update)
  );

  assign w_oe_mask = w_cfg[OUT_W-1:0];
  assign w_div     = w_cfg[tpm_div_lsb(OUT_W) +: DIV_W];
  assign w_sel     = w_cfg[tpm_sel_lsb(DIV_W, OUT_W) +: SEL_W];

`ifdef TPM_LOOPBACK_EN
  assign w_loop = w_cfg[CFG_W-1];
`else
  assign w_loop = 1'b0;
`endif

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    assign w_hit[k] = (w_sel == SEL_W'(k));
    assign bus.slot_in[k*IN_W +: IN_W] = bus.io_in[IN_LSB +: IN_W];
  end

  assign w_slot_ok = (|w_hit) & ~w_loop;
  assign w_sel_chg = w_cfg_update && (w_sel != sel_prev_q);
  assign w_div_chg = w_cfg_update && (w_div != div_prev_q);

  always_comb begin
    w_slot_data = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (w_hit[k]) begin
        w_slot_data = bus.slot_out[k*OUT_W +: OUT_W];
      end
    end
  end

  // Slot reset: counter reloads on a slot switch or any latch while still counting.
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (w_sel_chg || (w_cfg_update && (rst_cnt_q != '0))) begin
      rst_cnt_d = RST_CNT_W'(RST_CYC - 1);
    end else if (rst_cnt_q != '0) begin
      rst_cnt_d = rst_cnt_q - 1'b1;
    end
    slot_rst_d = '1;
    if (w_slot_ok && (rst_cnt_d == '0)) begin
      slot_rst_d = ~w_hit;
    end
  end

  always_comb begin
    div_cnt_d  = div_cnt_q;
    slot_clk_d = slot_clk_q;
    if (!w_slot_ok || w_sel_chg || w_div_chg) begin
      div_cnt_d  = '0;
      slot_clk_d = '0;
    end else if (div_cnt_q == w_div) begin
      div_cnt_d  = '0;
      slot_clk_d = slot_clk_q ^ w_hit;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_comb begin
    out_d = '0;
    oeb_d = '1;
    if (w_slot_ok) begin
      out_d = w_slot_data;
      oeb_d = ~w_oe_mask;
    end
`ifdef TPM_LOOPBACK_EN
    if (w_loop) begin
      out_d = '0;
      out_d[((IN_W < OUT_W) ? IN_W : OUT_W)-1:0] =
        bus.io_in[IN_LSB +: ((IN_W < OUT_W) ? IN_W : OUT_W)];
      oeb_d = ~w_oe_mask;
    end
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sel_prev_q <= '0;
      div_prev_q <= '0;
      rst_cnt_q  <= RST_CNT_W'(RST_CYC);
      div_cnt_q  <= '0;
      slot_clk_q <= '0;
      slot_rst_q <= '1;
      out_q      <= '0;
      oeb_q      <= '1;
    end else begin
      sel_prev_q <= w_sel;
      div_prev_q <= w_div;
      rst_cnt_q  <= rst_cnt_d;
      div_cnt_q  <= div_cnt_d;
      slot_clk_q <= slot_clk_d;
      slot_rst_q <= slot_rst_d;
      out_q      <= out_d;
      oeb_q      <= oeb_d;
    end
  end

  always_comb begin
    bus.io_out                     = '0;
    bus.io_out[OUT_LSB +: OUT_W]   = out_q;
    bus.io_oeb                     = '1;
    bus.io_oeb[OUT_LSB +: OUT_W]   = oeb_q;
  end

  assign bus.slot_clk = slot_clk_q;
  assign bus.slot_rst = slot_rst_q;

endmodule

`default_nettype wire
